seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked, multi-cycle ALU: the sequential successor to the team's 8-bit combinational ALU, keeping its 16-opcode command set. Operands enter through a valid/ready handshake. Results leave registered with status flags, held until consumed. MUL uses a shift-add datapath and DIV a restoring datapath, both iterative, so the block closes timing at any WIDTH and drops into a pipeline without a wide combinational multiplier or divider.

## Interface
- WIDTH, 8, operand width in bits (≥2); result width is 2*WIDTH.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/command presented.
- in_ready  out  1  block can accept; high only in IDLE and never while rst=1.
- a  in  WIDTH  operand A (unsigned).
- b  in  WIDTH  operand B (unsigned).
- command  in  4  opcode: ADD 0000, INC 0001, SUB 0010, DEC 0011, MUL 0100, DIV 0101, SHL 0110, SHR 0111, AND 1000, OR 1001, INV 1010, NAND 1011, NOR 1100, XOR 1101, XNOR 1110, BUFF 1111.
- enable  in  1  output enable; out reads 0 when low. Flags, out_valid and internal state are unaffected.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- out  out  2*WIDTH  registered result, gated by enable.
- carry  out  1  carry/borrow/shifted-out bit.
- zero  out  1  full 2*WIDTH result == 0.
- div_by_zero  out  1  DIV with b == 0.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Accept: in_valid && in_ready in IDLE. a, b and command are captured and inputs are ignored from then on.
- On accept, single-cycle opcodes go IDLE→DONE. MUL goes to MUL, and DIV goes to DIV (or directly to DONE when b == 0).
- MUL: WIDTH iterations of shift-add, one per cycle. Result is the full 2*WIDTH product; carry=0.
- DIV: WIDTH iterations of restoring division, one per cycle. out[WIDTH-1:0] = quotient, out[2W-1:W] = remainder; carry=0.
- DIV by zero: quotient all ones, remainder = a, div_by_zero=1, zero=0.
- div_by_zero is 0 for every other result.
- ADD: low WIDTH bits = a+b mod 2^WIDTH; carry = bit WIDTH of the sum.
- INC: low WIDTH bits = a+1 mod 2^WIDTH; carry = bit WIDTH.
- SUB: low WIDTH bits = a−b mod 2^WIDTH; carry = borrow (a<b).
- DEC: low WIDTH bits = a−1 mod 2^WIDTH; carry = borrow (a==0).
- SHL: a<<1; carry = a[WIDTH-1].
- SHR: a>>1; carry = a[0].
- Logic ops: bitwise on a,b; INV = ~a; BUFF = a; carry=0.
- For every non-MUL/DIV op the upper WIDTH bits of out are 0.
- zero is evaluated on the full 2*WIDTH result, before enable gating.
- DONE: out_valid=1; out and flags are stable. Leave DONE to IDLE on out_valid && out_ready.

## Timing
- Reset (rst=1 at an edge): state=IDLE, out=0, carry=0, zero=0, div_by_zero=0, out_valid=0.
- in_ready=0 while rst is high; it is 1 in the first cycle after release.
- Reset mid-MUL/DIV or in DONE aborts the operation. No out_valid is produced for it.
- Latency, accept edge at cycle N:
  - single-cycle ops and DIV-by-zero: out_valid from N+1.
  - MUL and DIV: out_valid from N+WIDTH+1.
- Backpressure: out_valid holds and out and flags stay constant for as long as out_ready=0.
- Result handshake at cycle M puts in_ready=1 at M+1, so sustained throughput is one op per (latency+1) cycles.
- in_valid while busy is ignored; the source holds until in_ready.
- out_ready with out_valid=0 has no effect.
- enable toggles affect out combinationally in the same cycle.

## Test plan
- Reset: drive rst for 2 cycles mid-MUL (a=5,b=4). Required: out_valid never rises, out=0, in_ready=1 the cycle after release.
- WIDTH=8, ADD a=200,b=100, out_ready=1. Required: out_valid at N+1, out=16'd44, carry=1, zero=0.
- WIDTH=8, SUB a=20,b=10 gives out=10, carry=0. Then SUB a=10,b=20 gives out=16'd246, carry=1.
- WIDTH=8, MUL a=255,b=255. Required: out_valid exactly at N+9, out=16'd65025. Hold out_ready=0 for 5 cycles; out stays stable and in_ready stays 0.
- WIDTH=8, DIV a=20,b=6 gives out at N+9 with quotient=3, remainder=2 (16'h0203). Then DIV a=7,b=0 gives out at N+1 = 16'h07FF, div_by_zero=1.
- WIDTH=16, AND a=16'h00F0,b=16'h0F00. Required: out=32'd0, zero=1. Drop enable during DONE: out=0 while out_valid stays 1. Then SHL a=16'h8001 gives out=32'h0002, carry=1.

Source files
------------

// File: rtl/seq_alu_if.sv
// Handshaked operand/result bundle for seq_alu: command side, result side and output enable.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         command;
  logic               enable;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out;
  logic               carry;
  logic               zero;
  logic               div_by_zero;

  modport master (
    output in_valid, a, b, command, enable, out_ready,
    input  in_ready, out_valid, out, carry, zero, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, command, enable, out_ready,
    output in_ready, out_valid, out, carry, zero, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV,
// registered result and flags held until the consumer takes them.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

  localparam logic [3:0] CMD_ADD  = 4'b0000;
  localparam logic [3:0] CMD_INC  = 4'b0001;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_DEC  = 4'b0011;
  localparam logic [3:0] CMD_MUL  = 4'b0100;
  localparam logic [3:0] CMD_DIV  = 4'b0101;
  localparam logic [3:0] CMD_SHL  = 4'b0110;
  localparam logic [3:0] CMD_SHR  = 4'b0111;
  localparam logic [3:0] CMD_AND  = 4'b1000;
  localparam logic [3:0] CMD_OR   = 4'b1001;
  localparam logic [3:0] CMD_INV  = 4'b1010;
  localparam logic [3:0] CMD_NAND = 4'b1011;
  localparam logic [3:0] CMD_NOR  = 4'b1100;
  localparam logic [3:0] CMD_XOR  = 4'b1101;
  localparam logic [3:0] CMD_XNOR = 4'b1110;
  localparam logic [3:0] CMD_BUFF = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    res_q, res_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             valid_q, valid_d;

  logic             in_ready_s;
  logic             accept_s;
  logic             last_iter_s;
  logic [WIDTH-1:0] lo_s;
  logic [WIDTH:0]   ext_s;
  logic [W2-1:0]    op_res_s;
  logic             op_carry_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [W2-1:0]    mul_next_s;
  logic [WIDTH:0]   div_trial_s;
  logic [W2-1:0]    div_next_s;

  assign in_ready_s  = (state_q == S_IDLE) && !rst;
  assign accept_s    = bus.in_valid && in_ready_s;
  assign last_iter_s = (cnt_q == CW'(WIDTH - 1));

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = valid_q;
  assign bus.out         = bus.enable ? res_q : {W2{1'b0}};
  assign bus.carry       = carry_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;

  // Single-cycle opcode result, taken straight from the presented operands.
  always_comb begin
    lo_s       = '0;
    ext_s      = '0;
    op_carry_s = 1'b0;
    case (bus.command)
      CMD_ADD: begin
        ext_s      = {1'b0, bus.a} + {1'b0, bus.b};
        lo_s       = ext_s[WIDTH-1:0];
        op_carry_s = ext_s[WIDTH];
      end
      CMD_INC: begin
        ext_s      = {1'b0, bus.a} + ONE_X;
        lo_s       = ext_s[WIDTH-1:0];
        op_carry_s = ext_s[WIDTH];
      end
      CMD_SUB: begin
        ext_s      = {1'b0, bus.a} - {1'b0, bus.b};
        lo_s       = ext_s[WIDTH-1:0];
        op_carry_s = ext_s[WIDTH];
      end
      CMD_DEC: begin
        ext_s      = {1'b0, bus.a} - ONE_X;
        lo_s       = ext_s[WIDTH-1:0];
        op_carry_s = ext_s[WIDTH];
      end
      CMD_SHL: begin
        lo_s       = {bus.a[WIDTH-2:0], 1'b0};
        op_carry_s = bus.a[WIDTH-1];
      end
      CMD_SHR: begin
        lo_s       = {1'b0, bus.a[WIDTH-1:1]};
        op_carry_s = bus.a[0];
      end
      CMD_AND:  lo_s = bus.a & bus.b;
      CMD_OR:   lo_s = bus.a | bus.b;
      CMD_INV:  lo_s = ~bus.a;
      CMD_NAND: lo_s = ~(bus.a & bus.b);
      CMD_NOR:  lo_s = ~(bus.a | bus.b);
      CMD_XOR:  lo_s = bus.a ^ bus.b;
      CMD_XNOR: lo_s = ~(bus.a ^ bus.b);
      CMD_BUFF: lo_s = bus.a;
      default:  lo_s = '0;
    endcase
    op_res_s = {{WIDTH{1'b0}}, lo_s};
  end

  // One iteration step for each datapath. acc holds {partial, multiplier} for MUL and
  // {remainder, dividend/quotient} for DIV; the DIV trial needs one extra bit of headroom.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
    div_trial_s = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
    if (!div_trial_s[WIDTH]) begin
      div_next_s = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {acc_q[W2-2:0], 1'b0};
    end
  end

  // Next-state and result capture for the control FSM.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          a_d   = bus.a;
          b_d   = bus.b;
          cnt_d = '0;
          if (bus.command == CMD_MUL) begin
            acc_d   = {{WIDTH{1'b0}}, bus.b};
            state_d = S_MUL;
          end else if (bus.command == CMD_DIV && bus.b != {WIDTH{1'b0}}) begin
            acc_d   = {{WIDTH{1'b0}}, bus.a};
            state_d = S_DIV;
          end else if (bus.command == CMD_DIV) begin
            res_d   = {bus.a, {WIDTH{1'b1}}};
            carry_d = 1'b0;
            zero_d  = 1'b0;
            dbz_d   = 1'b1;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            res_d   = op_res_s;
            carry_d = op_carry_s;
            zero_d  = (op_res_s == {W2{1'b0}});
            dbz_d   = 1'b0;
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        acc_d = mul_next_s;
        cnt_d = cnt_q + CW'(1);
        if (last_iter_s) begin
          res_d   = mul_next_s;
          carry_d = 1'b0;
          zero_d  = (mul_next_s == {W2{1'b0}});
          dbz_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        acc_d = div_next_s;
        cnt_d = cnt_q + CW'(1);
        if (last_iter_s) begin
          res_d   = div_next_s;
          carry_d = 1'b0;
          zero_d  = (div_next_s == {W2{1'b0}});
          dbz_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_seq_alu;
  localparam logic [3:0] C_ADD  = 4'd0;
  localparam logic [3:0] C_INC  = 4'd1;
  localparam logic [3:0] C_SUB  = 4'd2;
  localparam logic [3:0] C_DEC  = 4'd3;
  localparam logic [3:0] C_MUL  = 4'd4;
  localparam logic [3:0] C_DIV  = 4'd5;
  localparam logic [3:0] C_SHL  = 4'd6;
  localparam logic [3:0] C_SHR  = 4'd7;
  localparam logic [3:0] C_AND  = 4'd8;
  localparam logic [3:0] C_OR   = 4'd9;
  localparam logic [3:0] C_INV  = 4'd10;
  localparam logic [3:0] C_NAND = 4'd11;
  localparam logic [3:0] C_NOR  = 4'd12;
  localparam logic [3:0] C_XOR  = 4'd13;
  localparam logic [3:0] C_XNOR = 4'd14;
  localparam logic [3:0] C_BUFF = 4'd15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(8))  i8 ();
  seq_alu_if #(.WIDTH(16)) i16 ();

  seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));
  seq_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int w, input logic [3:0] cmd,
                                input longint unsigned a, input longint unsigned b,
                                output longint unsigned r, output bit c, output bit z,
                                output bit dz, output int lat);
    longint unsigned m;
    m   = (64'd1 << w) - 64'd1;
    r   = 64'd0;
    c   = 1'b0;
    dz  = 1'b0;
    lat = 1;
    case (cmd)
      C_ADD:  begin r = (a + b) & m; c = (a + b) > m; end
      C_INC:  begin r = (a + 64'd1) & m; c = (a == m); end
      C_SUB:  begin r = (a - b) & m; c = (a < b); end
      C_DEC:  begin r = (a - 64'd1) & m; c = (a == 64'd0); end
      C_MUL:  begin r = a * b; lat = w + 1; end
      C_DIV:  begin
        if (b == 64'd0) begin
          r  = (a << w) | m;
          dz = 1'b1;
        end else begin
          r   = ((a % b) << w) | (a / b);
          lat = w + 1;
        end
      end
      C_SHL:  begin r = (a << 1) & m; c = ((a >> (w - 1)) & 64'd1) != 64'd0; end
      C_SHR:  begin r = a >> 1; c = (a & 64'd1) != 64'd0; end
      C_AND:  r = a & b;
      C_OR:   r = a | b;
      C_INV:  r = ~a & m;
      C_NAND: r = ~(a & b) & m;
      C_NOR:  r = ~(a | b) & m;
      C_XOR:  r = a ^ b;
      C_XNOR: r = ~(a ^ b) & m;
      C_BUFF: r = a;
      default: r = 64'd0;
    endcase
    z = (r == 64'd0);
  endfunction

  task automatic drive(input int w, input logic [3:0] cmd, input longint unsigned a,
                       input longint unsigned b, input bit vld, input bit en);
    if (w == 8) begin
      i8.in_valid = vld; i8.command = cmd; i8.a = a[7:0]; i8.b = b[7:0]; i8.enable = en;
    end else begin
      i16.in_valid = vld; i16.command = cmd; i16.a = a[15:0]; i16.b = b[15:0]; i16.enable = en;
    end
  endtask

  task automatic set_ready(input int w, input bit r);
    if (w == 8) i8.out_ready = r;
    else        i16.out_ready = r;
  endtask

  task automatic set_enable(input int w, input bit e);
    if (w == 8) i8.enable = e;
    else        i16.enable = e;
  endtask

  task automatic sample(input int w, output longint unsigned o, output bit v, output bit r,
                        output bit c, output bit z, output bit d);
    if (w == 8) begin
      o = 64'(i8.out); v = i8.out_valid; r = i8.in_ready;
      c = i8.carry; z = i8.zero; d = i8.div_by_zero;
    end else begin
      o = 64'(i16.out); v = i16.out_valid; r = i16.in_ready;
      c = i16.carry; z = i16.zero; d = i16.div_by_zero;
    end
  endtask

  // One complete transaction: handshake in, latency, result/flags, backpressure, handshake out.
  task automatic do_op(input int w, input logic [3:0] cmd, input longint unsigned a,
                       input longint unsigned b, input int hold, input bit en, input bit en_test);
    longint unsigned er, eo, o;
    bit ec, ez, ed, v, r, c, z, d;
    int elat, n;
    string t;
    model(w, cmd, a, b, er, ec, ez, ed, elat);
    eo = en ? er : 64'd0;
    t  = $sformatf("w%0d cmd%0d a=%0h b=%0h", w, cmd, a, b);
    @(negedge clk);
    drive(w, cmd, a, b, 1'b1, en);
    set_ready(w, 1'b0);
    n = 0;
    sample(w, o, v, r, c, z, d);
    while (!r && n < 50) begin
      @(negedge clk);
      n++;
      sample(w, o, v, r, c, z, d);
    end
    chk({t, " in_ready"}, 64'(r), 64'd1);
    @(posedge clk);
    @(negedge clk);
    drive(w, ~cmd, ~a, ~b, 1'b0, en);
    n = 1;
    sample(w, o, v, r, c, z, d);
    while (!v && n < 100) begin
      @(negedge clk);
      n++;
      sample(w, o, v, r, c, z, d);
    end
    chk({t, " latency"}, 64'(n), 64'(elat));
    chk({t, " out"}, o, eo);
    chk({t, " carry"}, 64'(c), 64'(ec));
    chk({t, " zero"}, 64'(z), 64'(ez));
    chk({t, " dbz"}, 64'(d), 64'(ed));
    if (en_test) begin
      set_enable(w, 1'b0);
      #1;
      sample(w, o, v, r, c, z, d);
      chk({t, " gated out"}, o, 64'd0);
      chk({t, " gated valid"}, 64'(v), 64'd1);
      set_enable(w, en);
      #1;
      sample(w, o, v, r, c, z, d);
      chk({t, " ungated out"}, o, eo);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      sample(w, o, v, r, c, z, d);
      chk({t, " hold out"}, o, eo);
      chk({t, " hold valid"}, 64'(v), 64'd1);
      chk({t, " hold in_ready"}, 64'(r), 64'd0);
    end
    set_ready(w, 1'b1);
    @(negedge clk);
    set_ready(w, 1'b0);
    sample(w, o, v, r, c, z, d);
    chk({t, " valid after take"}, 64'(v), 64'd0);
    chk({t, " ready after take"}, 64'(r), 64'd1);
  endtask

  initial begin
    longint unsigned o, m, ra, rb;
    bit v, r, c, z, d;
    int rose;
    drive(8, C_ADD, 64'd0, 64'd0, 1'b0, 1'b1);
    drive(16, C_ADD, 64'd0, 64'd0, 1'b0, 1'b1);
    set_ready(8, 1'b0);
    set_ready(16, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sample(8, o, v, r, c, z, d);
    chk("rst valid", 64'(v), 64'd0);
    chk("rst out", o, 64'd0);
    chk("rst flags", {61'd0, c, z, d}, 64'd0);
    chk("rst in_ready", 64'(r), 64'd0);
    rst = 1'b0;
    #1;
    sample(8, o, v, r, c, z, d);
    chk("post-rst in_ready", 64'(r), 64'd1);

    // Reset in the middle of a MUL must abort it without a result.
    @(negedge clk);
    drive(8, C_MUL, 64'd5, 64'd4, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(8, C_MUL, 64'd5, 64'd4, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    rose = 0;
    repeat (2) begin
      @(negedge clk);
      sample(8, o, v, r, c, z, d);
      if (v) rose++;
      chk("mid-rst in_ready", 64'(r), 64'd0);
    end
    rst = 1'b0;
    #1;
    sample(8, o, v, r, c, z, d);
    chk("abort in_ready", 64'(r), 64'd1);
    chk("abort out", o, 64'd0);
    repeat (12) begin
      @(negedge clk);
      sample(8, o, v, r, c, z, d);
      if (v) rose++;
    end
    chk("abort out_valid rises", 64'(rose), 64'd0);

    do_op(8, C_ADD, 64'd200, 64'd100, 0, 1'b1, 1'b0);
    do_op(8, C_SUB, 64'd20, 64'd10, 0, 1'b1, 1'b0);
    do_op(8, C_SUB, 64'd10, 64'd20, 0, 1'b1, 1'b0);
    do_op(8, C_MUL, 64'd255, 64'd255, 5, 1'b1, 1'b0);
    do_op(8, C_DIV, 64'd20, 64'd6, 0, 1'b1, 1'b0);
    do_op(8, C_DIV, 64'd7, 64'd0, 0, 1'b1, 1'b0);
    do_op(8, C_DEC, 64'd0, 64'd0, 0, 1'b1, 1'b0);
    do_op(8, C_INC, 64'd255, 64'd0, 0, 1'b1, 1'b0);
    do_op(16, C_AND, 64'h00F0, 64'h0F00, 1, 1'b1, 1'b1);
    do_op(16, C_SHL, 64'h8001, 64'd0, 0, 1'b1, 1'b0);
    do_op(16, C_DIV, 64'hFFFF, 64'd1, 0, 1'b1, 1'b0);
    do_op(16, C_MUL, 64'hFFFF, 64'hFFFF, 2, 1'b1, 1'b0);

    for (int k = 0; k < 80; k++) begin
      int w;
      w  = (k % 2 == 0) ? 8 : 16;
      m  = (64'd1 << w) - 64'd1;
      ra = 64'($urandom) & m;
      rb = ($urandom_range(0, 7) == 0) ? 64'd0 : (64'($urandom) & m);
      do_op(w, 4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 2),
            $urandom_range(0, 3) != 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
